// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: ROB row layout, physical register and data word widths.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int PREG_W    = 6;
  localparam int WORD_W    = 32;

  typedef logic [$clog2(ROB_DEPTH)-1:0] rob_idx_t;
  typedef logic [PREG_W-1:0]            p_reg;
  typedef logic [WORD_W-1:0]            word;

  typedef struct packed {
    logic     valid;
    logic     complete;
    rob_idx_t ROBNumber;
    p_reg     PRegAddrDst;
    p_reg     OldPRegAddrDst;
    logic     RegWrite;
    logic     MemWrite;
    word      data;
  } rob_row_struct;

endpackage

// File: rtl/reorder_buffer_retire_sel.sv
// Combinational head-ordered pick of up to RET_W consecutive complete entries, wrapping mod DEPTH.
// Slot k only retires when every older slot retired this cycle.
module rob_retire_sel #(
  parameter  int DEPTH = 16,
  parameter  int RET_W = 2,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] vld_i,
  input  logic [DEPTH-1:0] cmp_i,
  input  logic [IW-1:0]    head_i,
  output logic             ret_vld_o [RET_W],
  output logic [IW-1:0]    ret_idx_o [RET_W]
);

  logic          chain;
  logic [IW-1:0] idx;

  always_comb begin
    chain = 1'b1;
    idx   = '0;
    for (int k = 0; k < RET_W; k++) begin
      idx          = head_i + IW'(k);
      ret_idx_o[k] = idx;
      ret_vld_o[k] = chain & vld_i[idx] & cmp_i[idx];
      chain        = ret_vld_o[k];
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate up to ALLOC_W rows, complete up to COMPL_W, retire up to RET_W per cycle.
// Retire/free outputs are registered; dispatch is throttled through o_free_count, overflow drops the whole group.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH   = ROB_DEPTH,
  parameter int ALLOC_W = 2,
  parameter int COMPL_W = 3,
  parameter int RET_W   = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_flush,
  input  rob_row_struct          i_alloc_rows      [0:ALLOC_W-1],
  input  rob_row_struct          i_compl_rows      [0:COMPL_W-1],
  output rob_row_struct          o_retire_rows     [0:RET_W-1],
  output p_reg                   o_free_preg       [0:RET_W-1],
  output logic                   o_free_preg_valid [0:RET_W-1],
  output logic [$clog2(DEPTH):0] o_free_count,
  output logic                   o_alloc_err,
  output logic                   o_compl_err
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  rob_row_struct ent_q [DEPTH];
  rob_row_struct ent_d [DEPTH];
  logic [IW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  rob_row_struct ret_q [0:RET_W-1];
  rob_row_struct ret_d [0:RET_W-1];
  p_reg          fp_q  [0:RET_W-1];
  p_reg          fp_d  [0:RET_W-1];
  logic          fpv_q [0:RET_W-1];
  logic          fpv_d [0:RET_W-1];
  logic          alloc_err_q, alloc_err_d, compl_err_q, compl_err_d;

  logic [DEPTH-1:0] ent_vld, ent_cmp;
  logic             ret_vld [RET_W];
  logic [IW-1:0]    ret_idx [RET_W];
  logic [CW-1:0]    free_cnt, n_req, n_ret;
  logic [IW-1:0]    pos, aidx, cidx;

  assign free_cnt = CW'(DEPTH) - count_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_vld[i] = ent_q[i].valid;
      ent_cmp[i] = ent_q[i].complete;
    end
  end

  rob_retire_sel #(.DEPTH(DEPTH), .RET_W(RET_W)) u_retire_sel (
    .vld_i     (ent_vld),
    .cmp_i     (ent_cmp),
    .head_i    (head_q),
    .ret_vld_o (ret_vld),
    .ret_idx_o (ret_idx)
  );

  // Fields of completion rows other than valid/ROBNumber/data carry no meaning here.
  logic unused_compl;
  always_comb begin
    unused_compl = 1'b0;
    for (int k = 0; k < COMPL_W; k++)
      unused_compl = unused_compl ^ i_compl_rows[k].complete ^ (^i_compl_rows[k].PRegAddrDst)
                     ^ (^i_compl_rows[k].OldPRegAddrDst) ^ i_compl_rows[k].RegWrite
                     ^ i_compl_rows[k].MemWrite;
  end

  always_comb begin
    ent_d       = ent_q;
    head_d      = head_q;
    tail_d      = tail_q;
    alloc_err_d = alloc_err_q;
    compl_err_d = compl_err_q;
    n_req       = '0;
    n_ret       = '0;
    pos         = '0;
    aidx        = '0;
    cidx        = '0;

    // Later slots overwrite earlier ones, so the highest duplicate slot wins.
    for (int k = 0; k < COMPL_W; k++) begin
      if (i_compl_rows[k].valid) begin
        cidx = IW'(i_compl_rows[k].ROBNumber);
        if (ent_q[cidx].valid) begin
          ent_d[cidx].complete = 1'b1;
          ent_d[cidx].data     = i_compl_rows[k].data;
        end else begin
          compl_err_d = 1'b1;
        end
      end
    end

    for (int s = 0; s < ALLOC_W; s++)
      if (i_alloc_rows[s].valid) n_req = n_req + CW'(1);

    if (n_req > free_cnt) begin
      alloc_err_d = 1'b1;
      n_req       = '0;
    end else begin
      for (int s = 0; s < ALLOC_W; s++) begin
        if (i_alloc_rows[s].valid) begin
          aidx                 = tail_q + pos;
          ent_d[aidx]          = i_alloc_rows[s];
          ent_d[aidx].complete = 1'b0;
          if (i_alloc_rows[s].ROBNumber != rob_idx_t'(aidx)) alloc_err_d = 1'b1;
          pos = pos + IW'(1);
        end
      end
      tail_d = tail_q + pos;
    end

    for (int k = 0; k < RET_W; k++) begin
      ret_d[k] = '0;
      fp_d[k]  = '0;
      fpv_d[k] = 1'b0;
      if (ret_vld[k]) begin
        ret_d[k]            = ent_q[ret_idx[k]];
        fp_d[k]             = ent_q[ret_idx[k]].OldPRegAddrDst;
        fpv_d[k]            = ent_q[ret_idx[k]].RegWrite & (ent_q[ret_idx[k]].OldPRegAddrDst != '0);
        ent_d[ret_idx[k]]   = '0;
        n_ret               = n_ret + CW'(1);
      end
    end
    head_d  = head_q + n_ret[IW-1:0];
    count_d = count_q + n_req - n_ret;

    // Flush discards everything this cycle would have done except the sticky error history.
    if (i_flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      for (int k = 0; k < RET_W; k++) begin
        ret_d[k] = '0;
        fp_d[k]  = '0;
        fpv_d[k] = 1'b0;
      end
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      alloc_err_d = alloc_err_q;
      compl_err_d = compl_err_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      for (int k = 0; k < RET_W; k++) begin
        ret_q[k] <= '0;
        fp_q[k]  <= '0;
        fpv_q[k] <= 1'b0;
      end
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      alloc_err_q <= 1'b0;
      compl_err_q <= 1'b0;
    end else begin
      ent_q       <= ent_d;
      ret_q       <= ret_d;
      fp_q        <= fp_d;
      fpv_q       <= fpv_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      alloc_err_q <= alloc_err_d;
      compl_err_q <= compl_err_d;
    end
  end

  assign o_retire_rows     = ret_q;
  assign o_free_preg       = fp_q;
  assign o_free_preg_valid = fpv_q;
  assign o_free_count      = free_cnt;
  assign o_alloc_err       = alloc_err_q;
  assign o_compl_err       = compl_err_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: hand-computed expectations for alloc, completion, retire, wrap, flush and reset.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic          clk, rst_n, flush;
  rob_row_struct alloc_rows [0:1];
  rob_row_struct compl_rows [0:2];
  rob_row_struct ret_rows   [0:1];
  p_reg          free_preg  [0:1];
  logic          free_vld   [0:1];
  logic [4:0]    free_cnt;
  logic          aerr, cerr;
  int            checks   = 0;
  int            failures = 0;

  reorder_buffer dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_flush           (flush),
    .i_alloc_rows      (alloc_rows),
    .i_compl_rows      (compl_rows),
    .o_retire_rows     (ret_rows),
    .o_free_preg       (free_preg),
    .o_free_preg_valid (free_vld),
    .o_free_count      (free_cnt),
    .o_alloc_err       (aerr),
    .o_compl_err       (cerr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_ret(input string tag, input int k, input bit v, input int rob, input int d);
    if (v) begin
      chk({tag, "_vld"}, 64'(ret_rows[k].valid), 64'(1));
      chk({tag, "_cmp"}, 64'(ret_rows[k].complete), 64'(1));
      chk({tag, "_rob"}, 64'(ret_rows[k].ROBNumber), 64'(rob));
      chk({tag, "_dat"}, 64'(ret_rows[k].data), 64'(d));
    end else begin
      chk({tag, "_idle"}, 64'(ret_rows[k]), 64'(0));
    end
  endtask

  task automatic chk_free(input string tag, input int k, input bit v, input int p);
    chk({tag, "_fvld"}, 64'(free_vld[k]), 64'(v));
    if (v) chk({tag, "_preg"}, 64'(free_preg[k]), 64'(p));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) alloc_rows[i] = '0;
    for (int i = 0; i < 3; i++) compl_rows[i] = '0;
  endtask

  task automatic alloc(input int s, input int rob, input int old, input bit rw, input bit mw);
    alloc_rows[s]                = '0;
    alloc_rows[s].valid          = 1'b1;
    alloc_rows[s].ROBNumber      = rob_idx_t'(rob);
    alloc_rows[s].PRegAddrDst    = p_reg'(33 + rob);
    alloc_rows[s].OldPRegAddrDst = p_reg'(old);
    alloc_rows[s].RegWrite       = rw;
    alloc_rows[s].MemWrite       = mw;
  endtask

  task automatic compl(input int s, input int rob, input int d);
    compl_rows[s]           = '0;
    compl_rows[s].valid     = 1'b1;
    compl_rows[s].ROBNumber = rob_idx_t'(rob);
    compl_rows[s].data      = word'(d);
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    #12;
    chk("rst_free_cnt", 64'(free_cnt), 64'(16));
    chk_ret("rst_r0", 0, 0, 0, 0);
    chk_ret("rst_r1", 1, 0, 0, 0);
    chk("rst_fp0", 64'(free_preg[0]), 64'(0));
    chk_free("rst_f0", 0, 0, 0);
    chk_free("rst_f1", 1, 0, 0);
    chk("rst_aerr", 64'(aerr), 64'(0));
    chk("rst_cerr", 64'(cerr), 64'(0));
    rst_n = 1'b1;
    step(); step();
    chk("idle_free_cnt", 64'(free_cnt), 64'(16));

    // Basic pair: alloc, complete, retire together
    alloc(0, 0, 1, 1, 0); alloc(1, 1, 2, 1, 0); step(); clr();
    chk("a01_free_cnt", 64'(free_cnt), 64'(14));
    compl(0, 0, 'hA5); compl(1, 1, 'h5A); step(); clr();
    chk_ret("c01_hold", 0, 0, 0, 0);
    step();
    chk_ret("ret0", 0, 1, 0, 'hA5);
    chk_ret("ret1", 1, 1, 1, 'h5A);
    chk_free("fp0", 0, 1, 1);
    chk_free("fp1", 1, 1, 2);
    chk("ret01_free_cnt", 64'(free_cnt), 64'(16));
    step();
    chk_ret("ret_once", 0, 0, 0, 0);
    chk_free("fp_once", 0, 0, 0);

    // Out-of-order completion, triple completion, invalid target and duplicate slots
    alloc(0, 2, 3, 1, 0); alloc(1, 3, 0, 1, 0); step();
    alloc(0, 4, 5, 0, 0); alloc(1, 5, 6, 1, 1); step(); clr();
    chk("a25_free_cnt", 64'(free_cnt), 64'(12));
    compl(0, 3, 'h33); compl(1, 4, 'h44); compl(2, 5, 'h55); step(); clr(); step();
    chk_ret("ooo_hold", 0, 0, 0, 0);
    chk("ooo_cerr0", 64'(cerr), 64'(0));
    compl(0, 2, 'h11); compl(1, 9, 'h99); compl(2, 2, 'h22); step(); clr();
    chk("inv_cerr1", 64'(cerr), 64'(1));
    step();
    chk_ret("ooo_r0", 0, 1, 2, 'h22);
    chk_ret("ooo_r1", 1, 1, 3, 'h33);
    chk_free("ooo_f0", 0, 1, 3);
    chk_free("ooo_f1_old0", 1, 0, 0);
    step();
    chk_ret("st_r0", 0, 1, 4, 'h44);
    chk_ret("st_r1", 1, 1, 5, 'h55);
    chk("st_memwrite", 64'(ret_rows[1].MemWrite), 64'(1));
    chk_free("st_f0_norw", 0, 0, 0);
    chk_free("st_f1", 1, 1, 6);
    chk("st_free_cnt", 64'(free_cnt), 64'(16));

    // Fill all 16 entries from head 6, then overflow
    for (int i = 0; i < 8; i++) begin
      alloc(0, (6 + 2 * i) % 16, 1, 1, 0);
      alloc(1, (7 + 2 * i) % 16, 2, 1, 0);
      step();
    end
    clr();
    chk("full_free_cnt", 64'(free_cnt), 64'(0));
    chk("full_aerr0", 64'(aerr), 64'(0));
    alloc(0, 6, 1, 1, 0); step(); clr();
    chk("ovf_aerr", 64'(aerr), 64'(1));
    chk("ovf_free_cnt", 64'(free_cnt), 64'(0));

    // Drain 6..14, leaving 15 to pair with 0 across the wrap
    compl(0, 6, 6);   compl(1, 7, 7);   compl(2, 8, 8);   step();
    compl(0, 9, 9);   compl(1, 10, 10); compl(2, 11, 11); step();
    compl(0, 12, 12); compl(1, 13, 13); compl(2, 14, 14); step();
    clr();
    repeat (6) step();
    chk("drain_free_cnt", 64'(free_cnt), 64'(9));
    chk_ret("drain_idle", 0, 0, 0, 0);
    compl(0, 15, 'hF); compl(1, 0, 'h100); step(); clr(); step();
    chk_ret("wrap_r0", 0, 1, 15, 'hF);
    chk_ret("wrap_r1", 1, 1, 0, 'h100);
    chk("wrap_free_cnt", 64'(free_cnt), 64'(11));
    step();
    chk_ret("wrap_after", 0, 0, 0, 0);

    // Flush with 5 live rows, a pending retire, alloc and completion in the same cycle
    compl(0, 1, 'h1); step(); clr();
    flush = 1'b1; alloc(0, 6, 1, 1, 0); compl(0, 2, 'h2); step(); clr();
    chk("fl_free_cnt", 64'(free_cnt), 64'(16));
    chk_ret("fl_r0", 0, 0, 0, 0);
    chk_free("fl_f0", 0, 0, 0);
    chk("fl_aerr_kept", 64'(aerr), 64'(1));
    chk("fl_cerr_kept", 64'(cerr), 64'(1));
    step();
    chk("fl2_free_cnt", 64'(free_cnt), 64'(16));
    chk_ret("fl2_r0", 0, 0, 0, 0);
    alloc(0, 0, 1, 1, 0); step(); clr();
    chk("postfl_free_cnt", 64'(free_cnt), 64'(15));

    // Reset mid-operation, then ROBNumber mismatch on allocation
    rst_n = 1'b0;
    #2;
    chk("mrst_free_cnt", 64'(free_cnt), 64'(16));
    chk("mrst_aerr", 64'(aerr), 64'(0));
    chk("mrst_cerr", 64'(cerr), 64'(0));
    rst_n = 1'b1;
    step();
    alloc(0, 5, 7, 1, 0); step(); clr();
    chk("mis_aerr", 64'(aerr), 64'(1));
    chk("mis_free_cnt", 64'(free_cnt), 64'(15));
    compl(0, 0, 'h77); step(); clr(); step();
    chk_ret("mis_r0", 0, 1, 5, 'h77);
    chk_free("mis_f0", 0, 1, 7);
    chk("mis_free_cnt2", 64'(free_cnt), 64'(16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
